// File: rtl/display_pkg.sv
// Shared constants for the hex-display source selector and its board-key helpers.
package display_pkg;

    localparam int SRC_COUNT = 4;
    localparam int SEL_W     = 2;
    localparam int DATA_W    = 32;

    // Defaults assume the 50 MHz DE2 clock: 20 ms debounce, 10 Hz refresh.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REFRESH_CYCLES_DEF  = 5000000;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces an active-low board key; flags each accepted press.
module key_debouncer
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int               CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Press is decoded on the accepting edge itself so the consumer can act
    // on the same edge the debounced level falls.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_o = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_o = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_source_select.sv
// Picks one of four debug words with a debounced key and feeds the hex display
// decoder a registered snapshot, refreshed periodically unless frozen.
module display_source_select
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REFRESH_CYCLES  = REFRESH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              keyNextN,
    input  logic              freeze,
    input  logic [DATA_W-1:0] src0,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] src3,
    output logic [DATA_W-1:0] displayData32,
    output logic [SEL_W-1:0]  srcSel,
    output logic              frozen,
    output logic              updatePulse
);

    localparam int               REF_W    = cnt_w(REFRESH_CYCLES);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    logic              press;
    logic              freeze_meta_q;
    logic              freeze_sync_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;
    logic              sel_cap_q;
    logic              sel_cap_d;
    logic [REF_W-1:0]  refresh_q;
    logic [REF_W-1:0]  refresh_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              pulse_q;
    logic              pulse_d;
    logic              refresh_term;
    logic [DATA_W-1:0] src_arr [SRC_COUNT];

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (keyNextN),
        .press_o (press)
    );

    assign src_arr[0]   = src0;
    assign src_arr[1]   = src1;
    assign src_arr[2]   = src2;
    assign src_arr[3]   = src3;
    assign refresh_term = (refresh_q == REF_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_meta_q <= 1'b0;
            freeze_sync_q <= 1'b0;
            sel_q         <= '0;
            sel_cap_q     <= 1'b0;
            refresh_q     <= '0;
            data_q        <= '0;
            pulse_q       <= 1'b0;
        end else begin
            freeze_meta_q <= freeze;
            freeze_sync_q <= freeze_meta_q;
            sel_q         <= sel_d;
            sel_cap_q     <= sel_cap_d;
            refresh_q     <= refresh_d;
            data_q        <= data_d;
            pulse_q       <= pulse_d;
        end
    end

    // A selection capture overrides freeze so the new source is shown once;
    // if it lands on the terminal count both collapse into one capture.
    always_comb begin
        sel_d     = sel_q;
        sel_cap_d = 1'b0;
        refresh_d = refresh_q + 1'b1;
        data_d    = data_q;
        pulse_d   = 1'b0;
        if (press) begin
            sel_d     = sel_q + 1'b1;
            sel_cap_d = 1'b1;
        end
        if (sel_cap_q || refresh_term) begin
            refresh_d = '0;
        end
        if (sel_cap_q || (refresh_term && !freeze_sync_q)) begin
            data_d  = src_arr[sel_q];
            pulse_d = 1'b1;
        end
    end

    assign displayData32 = data_q;
    assign srcSel        = sel_q;
    assign frozen        = freeze_sync_q;
    assign updatePulse   = pulse_q;

endmodule

// File: tb/tb_display_source_select.sv
// Bench for display_source_select against an event-level reference model.
module tb_display_source_select;

    localparam int DEB = 4;
    localparam int REF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        keyNextN;
    logic        freeze;
    logic [31:0] src [4];
    logic [31:0] displayData32;
    logic [1:0]  srcSel;
    logic        frozen;
    logic        updatePulse;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_pulses = 0;

    // Reference model: key history (index 0 newest), freeze history, selection.
    logic        m_khist [DEB+1];
    logic        m_fhist [2];
    logic        m_deb;
    int          m_sel;
    logic        m_pend;
    int          m_phase;
    logic [31:0] m_disp;
    logic        m_pulse;

    always #5 clk = ~clk;

    display_source_select #(
        .DEBOUNCE_CYCLES(DEB),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .keyNextN     (keyNextN),
        .freeze       (freeze),
        .src0         (src[0]),
        .src1         (src[1]),
        .src2         (src[2]),
        .src3         (src[3]),
        .displayData32(displayData32),
        .srcSel       (srcSel),
        .frozen       (frozen),
        .updatePulse  (updatePulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DEB; i++) m_khist[i] = 1'b1;
        m_fhist[0] = 1'b0;
        m_fhist[1] = 1'b0;
        m_deb   = 1'b1;
        m_sel   = 0;
        m_pend  = 1'b0;
        m_phase = 0;
        m_disp  = 32'h0;
        m_pulse = 1'b0;
    endtask

    // A key level is accepted once the synchronised key (raw delayed two
    // samples) has disagreed with the debounced level for DEB straight cycles.
    task automatic model_step();
        logic accept;
        logic capture;
        accept = 1'b1;
        for (int i = 1; i <= DEB; i++) if (m_khist[i] == m_deb) accept = 1'b0;
        capture = m_pend || ((m_phase == REF - 1) && !m_fhist[1]);
        if (capture) m_disp = src[m_sel];
        m_pulse = capture;
        m_phase = m_pend ? 0 : (m_phase + 1) % REF;
        m_pend  = 1'b0;
        if (accept) begin
            m_deb = ~m_deb;
            if (m_deb == 1'b0) begin
                m_sel  = (m_sel + 1) % 4;
                m_pend = 1'b1;
            end
        end
        for (int i = DEB; i > 0; i--) m_khist[i] = m_khist[i-1];
        m_khist[0] = keyNextN;
        m_fhist[1] = m_fhist[0];
        m_fhist[0] = freeze;
    endtask

    task automatic check_outputs();
        check_eq("displayData32", displayData32, m_disp);
        check_eq("srcSel", 32'(srcSel), 32'(m_sel));
        check_eq("frozen", 32'(frozen), 32'(m_fhist[1]));
        check_eq("updatePulse", 32'(updatePulse), 32'(m_pulse));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (updatePulse) dut_pulses++;
        check_outputs();
    endtask

    task automatic press(input int low_cycles, input int high_cycles);
        keyNextN = 1'b0;
        repeat (low_cycles) cycle();
        keyNextN = 1'b1;
        repeat (high_cycles) cycle();
    endtask

    task automatic set_plan_sources();
        src[0] = 32'h00400000;
        src[1] = 32'h8C090004;
        src[2] = 32'h0000002A;
        src[3] = 32'hDEADBEEF;
    endtask

    initial begin
        rst_n    = 1'b0;
        keyNextN = 1'b1;
        freeze   = 1'b0;
        set_plan_sources();
        model_reset();
        #2;
        check_eq("rst_data", displayData32, 32'h0);
        check_eq("rst_sel", 32'(srcSel), 32'h0);
        check_eq("rst_frozen", 32'(frozen), 32'h0);
        check_eq("rst_pulse", 32'(updatePulse), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First periodic capture arrives on the eighth edge after release.
        for (int i = 1; i <= 8; i++) begin
            cycle();
            check_eq("first_refresh_pulse", 32'(updatePulse), (i == 8) ? 32'h1 : 32'h0);
        end
        check_eq("first_refresh_data", displayData32, 32'h00400000);
        repeat (16) cycle();

        // Clean press: select at edge 2+DEB, capture one edge later.
        keyNextN = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 5) check_eq("press_sel_before", 32'(srcSel), 32'h0);
            if (i == 6) check_eq("press_sel_after", 32'(srcSel), 32'h1);
            if (i == 7) begin
                check_eq("press_capture_pulse", 32'(updatePulse), 32'h1);
                check_eq("press_capture_data", displayData32, 32'h8C090004);
            end
        end
        keyNextN = 1'b1;
        repeat (12) cycle();
        check_eq("release_no_event", 32'(srcSel), 32'h1);

        // Bounce shorter than the debounce window.
        for (int b = 0; b < 3; b++) begin
            keyNextN = 1'b0;
            repeat (3) cycle();
            keyNextN = 1'b1;
            repeat (2) cycle();
        end
        repeat (10) cycle();
        check_eq("bounce_sel", 32'(srcSel), 32'h1);

        // Wrap through all sources.
        for (int k = 1; k <= 7; k++) begin
            press(10, 8);
            check_eq("wrap_sel", 32'(srcSel), 32'((1 + k) % 4));
        end

        // Freeze: periodic captures stop, a selection still shows once.
        freeze = 1'b1;
        repeat (3) cycle();
        check_eq("frozen_led", 32'(frozen), 32'h1);
        src[0] = 32'h12345678;
        dut_pulses = 0;
        repeat (20) cycle();
        check_eq("frozen_no_pulse", 32'(dut_pulses), 32'h0);
        check_eq("frozen_hold", displayData32, 32'h00400000);
        press(10, 10);
        check_eq("frozen_press_pulses", 32'(dut_pulses), 32'h1);
        check_eq("frozen_press_data", displayData32, 32'h8C090004);
        repeat (20) cycle();
        check_eq("frozen_after_pulses", 32'(dut_pulses), 32'h1);
        check_eq("frozen_after_data", displayData32, 32'h8C090004);
        freeze = 1'b0;
        set_plan_sources();
        repeat (4) cycle();

        // Coincidence: selection capture on refresh terminal count.
        begin
            int guard;
            guard = 0;
            while (m_phase != 1 && guard < 20) begin
                cycle();
                guard++;
            end
            check_eq("coinc_align", 32'(m_phase), 32'h1);
        end
        keyNextN = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            if (i == 10) keyNextN = 1'b1;
            check_eq("coinc_pulse", 32'(updatePulse), (i == 7 || i == 15) ? 32'h1 : 32'h0);
        end
        repeat (4) cycle();

        // Reset in the middle of debouncing a press started at srcSel=2.
        begin
            int guard;
            guard = 0;
            while (m_sel != 2 && guard < 4) begin
                press(10, 8);
                guard++;
            end
            check_eq("pre_reset_sel", 32'(srcSel), 32'h2);
        end
        keyNextN = 1'b0;
        repeat (4) cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_data", displayData32, 32'h0);
        check_eq("midrst_sel", 32'(srcSel), 32'h0);
        check_eq("midrst_frozen", 32'(frozen), 32'h0);
        check_eq("midrst_pulse", 32'(updatePulse), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle();
        check_eq("post_reset_sel", 32'(srcSel), 32'h1);
        check_eq("post_reset_data", displayData32, 32'h8C090004);
        keyNextN = 1'b1;
        repeat (10) cycle();

        // Randomised key bursts, freeze toggles and source changes.
        for (int r = 0; r < 100; r++) begin
            int run;
            keyNextN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) freeze = ~freeze;
            if ($urandom_range(0, 3) == 0) src[$urandom_range(0, 3)] = $urandom;
            run = $urandom_range(1, 8);
            repeat (run) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
